// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the RV32I execute-stage ALU: datapath width,
//   op_code encodings (ALU_*), the shifter mode enum and a bit-reverse helper.
//   Every block that drives or decodes op_code imports this package.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Only a 32-bit datapath is supported.
  localparam int XLEN = 32;

  // Op-code encodings; 4'd10..4'd15 are undefined and yield a zero result.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    SHIFT_SLL,
    SHIFT_SRL,
    SHIFT_SRA
  } shift_mode_e;

  // Mirror a word end-for-end; lets one right-shifting barrel also shift left.
  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
//   Operand/result bundle between the core (master) and the ALU (slave).
//   a, b      operands A and B
//   op_code   operation select (ALU_* from alu_pkg)
//   result    combinational result, zero latency
//   result_r  result registered on the rising clock edge
//   zero      combinational (result == 0), used for branch compare
// -----------------------------------------------------------------------------
interface alu_if;
  import alu_pkg::*;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      op_code;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] result_r;
  logic            zero;

  modport master (
    output a, b, op_code,
    input  result, result_r, zero
  );

  modport slave (
    input  a, b, op_code,
    output result, result_r, zero
  );

endinterface

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
//   Five-stage barrel shifter for SLL/SRL/SRA.
//   a_i      value to shift
//   shamt_i  shift amount (0..31)
//   mode_i   SHIFT_SLL, SHIFT_SRL or SHIFT_SRA
//   out_o    shifted value
//   Left shifts reuse the right-shifting stages by reversing the word before
//   and after, so only one set of stages exists.
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [4:0]      shamt_i,
  input  shift_mode_e     mode_i,
  output logic [XLEN-1:0] out_o
);

  logic            fill;
  logic [XLEN-1:0] v;

  // NOTE: every variable written here gets a value before any conditional
  // update, so no path leaves it holding its old value and no latch appears.
  always_comb begin
    fill = (mode_i == SHIFT_SRA) ? a_i[XLEN-1] : 1'b0;
    v    = (mode_i == SHIFT_SLL) ? bit_reverse(a_i) : a_i;

    if (shamt_i[0]) v = {fill, v[XLEN-1:1]};
    if (shamt_i[1]) v = {{2{fill}}, v[XLEN-1:2]};
    if (shamt_i[2]) v = {{4{fill}}, v[XLEN-1:4]};
    if (shamt_i[3]) v = {{8{fill}}, v[XLEN-1:8]};
    if (shamt_i[4]) v = {{16{fill}}, v[XLEN-1:16]};

    out_o = (mode_i == SHIFT_SLL) ? bit_reverse(v) : v;
  end

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   32-bit RV32I integer ALU for the execute stage.
//   clk   system clock
//   rst   synchronous reset, active-high (clears result_r only)
//   bus   alu_if.slave: a, b, op_code in; result, zero (combinational) and
//         result_r (one-cycle registered copy of result) out
//   All arithmetic wraps modulo 2^32. Shifts use b[4:0] only. Undefined
//   op_codes produce zero.
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  shift_mode_e     shift_mode;
  logic [XLEN-1:0] shift_out;
  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;

  // Shifter mode only matters for the three shift ops; SRL is a harmless idle value.
  always_comb begin
    shift_mode = SHIFT_SRL;
    if (bus.op_code == ALU_SLL) shift_mode = SHIFT_SLL;
    if (bus.op_code == ALU_SRA) shift_mode = SHIFT_SRA;
  end

  alu_shifter u_shifter (
    .a_i     (bus.a),
    .shamt_i (bus.b[4:0]),
    .mode_i  (shift_mode),
    .out_o   (shift_out)
  );

  always_comb begin
    result_d = '0;
    case (bus.op_code)
      ALU_ADD:  result_d = bus.a + bus.b;
      ALU_SUB:  result_d = bus.a - bus.b;
      ALU_XOR:  result_d = bus.a ^ bus.b;
      ALU_OR:   result_d = bus.a | bus.b;
      ALU_AND:  result_d = bus.a & bus.b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result_d = shift_out;
      ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      default:  result_d = '0;
    endcase
  end

  // NOTE: registered state is updated with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) result_q <= '0;
    else     result_q <= result_d;
  end

  assign bus.result   = result_d;
  assign bus.zero     = (result_d == '0);
  assign bus.result_r = result_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for alu: directed corner cases, register/reset
//   behaviour, then randomized vectors over all 16 op_codes compared against
//   an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model from the operation rules, using plain arithmetic:
  // shifts as multiply/divide by powers of two, signed compare by sign cases.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] pow;
    pow = 32'd1 << b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a ^ b;
      4'd3: return a | b;
      4'd4: return a & b;
      4'd5: return a * pow;
      4'd6: return a / pow;
      4'd7: return a[31] ? ~((~a) / pow) : (a / pow);
      4'd8: begin
        if (a[31] != b[31]) return {31'b0, a[31]};
        return {31'b0, a < b};
      end
      4'd9: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  // Drive at the falling edge, sample 1 time unit later.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.op_code = op;
    bus.a       = a;
    bus.b       = b;
    #1;
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    check({tag, " result"}, bus.result, exp);
    check({tag, " zero"}, {31'b0, bus.zero}, {31'b0, exp == 32'h0});
  endtask

  initial begin
    bus.a       = '0;
    bus.b       = '0;
    bus.op_code = ALU_ADD;

    // Reset held while operands produce a nonzero result: result_r must still be 0.
    drive(ALU_ADD, 32'd3, 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset result_r", bus.result_r, 32'h0);
    check("reset comb result", bus.result, 32'd7);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release result_r", bus.result_r, 32'd7);

    // Mid-stream reset wins at that edge, then the pipeline resumes.
    drive(ALU_ADD, 32'd5, 32'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midstream rst result_r", bus.result_r, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post rst result_r", bus.result_r, 32'd11);

    // Directed corner cases.
    directed("add wrap", ALU_ADD, 32'd1, 32'hFFFF_FFFF, 32'h0);
    directed("sub wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    directed("xor spot", ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    directed("or spot",  ALU_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    directed("and spot", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    directed("srl 31",   ALU_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001);
    directed("sra 31",   ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    directed("sll b21",  ALU_SLL, 32'd1, 32'h21, 32'd2);
    directed("sll b20",  ALU_SLL, 32'h1234_5678, 32'h20, 32'h1234_5678);
    directed("slt neg",  ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    directed("sltu neg", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    directed("undef 15", 4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
    directed("undef 10", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    // Randomized sweep over every op_code, including undefined ones.
    for (int op = 0; op < 16; op++) begin
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] ra, rb, exp;
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 7) == 0) rb = ra;
        exp = ref_alu(op[3:0], ra, rb);
        drive(op[3:0], ra, rb);
        check($sformatf("rand op%0d result", op), bus.result, exp);
        check($sformatf("rand op%0d zero", op), {31'b0, bus.zero}, {31'b0, exp == 32'h0});
        @(posedge clk); #1;
        check($sformatf("rand op%0d result_r", op), bus.result_r, exp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
